l0a_ifm_pingpong: RTL
=====================

L0A_IFM_PINGPONG -- requirements
Module: l0a_ifm_pingpong

Interface
REQ-001 SHALL have parameter SIZE, default 8, number of img2col lanes (one 128-bit pixel word per lane per row).
REQ-002 SHALL have parameter DEPTH, default 32, rows per bank; fixed by the 5-bit per-lane row address.
REQ-003 clock  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 ifm_wr_en  input  SIZE  per-lane row write strobe from the img2col lanes.
REQ-006 ifm_wr_addr  input  5*SIZE  per-lane row address; lane i uses bits [5i+4:5i].
REQ-007 pixels_in  input  128*SIZE  per-lane write data; lane i uses bits [128i+127:128i].
REQ-008 i2c_done  input  1  one-cycle pulse: the current tile is complete and the write bank is closed.
REQ-009 buf_ready  output  1  the write bank is empty and upstream may start a tile.
REQ-010 out_valid  output  1  out_data holds a valid row.
REQ-011 out_ready  input  1  consumer (cube) accepts the row on out_valid && out_ready.
REQ-012 out_data  output  128*SIZE  row out_row of the read bank, all lanes concatenated as on input.
REQ-013 out_row  output  5  index of the row currently presented.
REQ-014 out_last  output  1  the presented row is the final row of the bank.
REQ-015 ovf_err  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL hold two banks (0,1), each SIZE x DEPTH x 128 bits, with a per-bank full flag and a 6-bit row count.
REQ-017 SHALL keep a write-bank pointer wr_bank and a read-bank pointer rd_bank; each toggles only as stated below, so banks are read in fill order.
REQ-018 Write: for each lane i with ifm_wr_en[i]=1 and full[wr_bank]=0, SHALL store that lane's word at [wr_bank][i][addr_i] on the clock edge.
REQ-019 SHALL track, per bank under fill, hi = max(addr_i)+1 over all accepted lane writes since the bank was opened; the bank opens with hi=0.
REQ-020 On i2c_done with full[wr_bank]=0 and hi>0: SHALL set full[wr_bank]=1, rows[wr_bank]=hi, toggle wr_bank, and reset hi to 0, all on the same edge.
REQ-021 Lane writes in the same cycle as i2c_done SHALL be stored and SHALL be included in hi before it is latched into rows.
REQ-022 i2c_done with hi=0 (empty tile) SHALL be ignored: no state change, no error.
REQ-023 buf_ready SHALL equal ~full[wr_bank] (combinational from registered state).
REQ-024 Read: out_valid SHALL equal full[rd_bank]; out_data SHALL be the asynchronous read of [rd_bank][*][rd_ptr]; out_row=rd_ptr; out_last=out_valid && (rd_ptr==rows[rd_bank]-1).
REQ-025 A row becomes visible on out_valid in the cycle after the i2c_done edge that closes its bank (latency 1 cycle).
REQ-026 On out_valid && out_ready && !out_last: SHALL increment rd_ptr by 1.
REQ-027 On out_valid && out_ready && out_last: SHALL clear full[rd_bank], zero rd_ptr, and toggle rd_bank.
REQ-028 out_data, out_row and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Simultaneous release of the read bank (REQ-027) and close of the write bank (REQ-020) SHALL both take effect on the same edge.
REQ-030 Lane writes with full[wr_bank]=1 SHALL be dropped and SHALL set ovf_err; i2c_done with full[wr_bank]=1 SHALL be dropped and SHALL set ovf_err.
REQ-031 ovf_err SHALL be cleared only by reset.
REQ-032 With both banks full, buf_ready=0 until the read bank is released; the write bank becomes writable in the cycle after release.

Reset
REQ-033 rst_n=0 at a clock edge SHALL clear both full flags, both row counts, hi, rd_ptr, wr_bank, rd_bank, and ovf_err.
REQ-034 During and after reset: buf_ready=1, out_valid=0, out_last=0, out_row=0; memory contents are don't-care.
REQ-035 Reset asserted mid-tile or mid-readout SHALL discard all buffered tiles with no partial output.

Verification
REQ-036 Write rows 0..3 on all 8 lanes (data = {lane,row}), pulse i2c_done, out_ready=1 -> next cycle out_valid=1, rows 0..3 appear in order over 4 cycles, out_last on row 3, then out_valid=0.
REQ-037 Fill bank0 (4 rows), then bank1 (2 rows), out_ready=0 -> buf_ready=0 after the second done; extra write -> ovf_err=1; enable out_ready -> 4 rows of bank0 then 2 rows of bank1; buf_ready=1 the cycle after the bank0 release.
REQ-038 Lane 3 writes addr 31 only, with i2c_done in the same cycle -> rows=32, out_last at out_row=31.
REQ-039 Release of bank0's last row in the same cycle as bank1's i2c_done -> out_valid stays 1, bank1 row 0 presented the next cycle, no ovf_err.
REQ-040 i2c_done with no prior writes -> no out_valid, buf_ready stays 1; rst_n=0 during readout of row 2 -> next cycle out_valid=0, buf_ready=1, ovf_err=0.

Source files
------------

// File: rtl/l0a_ifm_pingpong.sv
// Ping-pong IFM row buffer between the img2col lanes and the cube.
// One bank fills while the other drains, and banks are drained in the order they were filled.
module l0a_ifm_pingpong #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 32
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [SIZE-1:0]     ifm_wr_en,
  input  logic [5*SIZE-1:0]   ifm_wr_addr,
  input  logic [128*SIZE-1:0] pixels_in,
  input  logic                i2c_done,
  output logic                buf_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [128*SIZE-1:0] out_data,
  output logic [4:0]          out_row,
  output logic                out_last,
  output logic                ovf_err
);

  localparam int W  = 128;
  localparam int AW = 5;

  logic [W-1:0] mem_q [2][SIZE][DEPTH];

  logic [1:0]    full_q, full_d;
  logic [AW:0]   rows_q [2];
  logic [AW:0]   rows_d [2];
  logic [AW:0]   hi_q, hi_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          ovf_q, ovf_d;

  logic          wr_open;
  logic [AW:0]   hi_new;
  logic          close_bank;
  logic          rd_fire;
  logic          release_bank;

  assign wr_open      = ~full_q[wr_bank_q];
  assign rd_fire      = out_valid && out_ready;
  assign release_bank = rd_fire && out_last;
  assign close_bank   = i2c_done && wr_open && (hi_new != '0);

  // Same-cycle lane writes must be folded into hi before it is latched into rows.
  // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
  always_comb begin
    hi_new = hi_q;
    for (int i = 0; i < SIZE; i++) begin
      if (ifm_wr_en[i] && wr_open &&
          (({1'b0, ifm_wr_addr[AW*i +: AW]} + 6'd1) > hi_new)) begin
        hi_new = {1'b0, ifm_wr_addr[AW*i +: AW]} + 6'd1;
      end
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    full_d    = full_q;
    rows_d    = rows_q;
    hi_d      = hi_new;
    rd_ptr_d  = rd_ptr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    ovf_d     = ovf_q | (~wr_open & ((|ifm_wr_en) | i2c_done));

    if (close_bank) begin
      full_d[wr_bank_q] = 1'b1;
      rows_d[wr_bank_q] = hi_new;
      wr_bank_d         = ~wr_bank_q;
      hi_d              = '0;
    end

    // Close targets an empty bank and release a full one, so both can land on one edge.
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
      rd_ptr_d          = '0;
      rd_bank_d         = ~rd_bank_q;
    end else if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 5'd1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      full_q    <= '0;
      rows_q[0] <= '0;
      rows_q[1] <= '0;
      hi_q      <= '0;
      rd_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      rows_q    <= rows_d;
      hi_q      <= hi_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: the row storage has no reset; full flags alone decide what is readable.
  always_ff @(posedge clock) begin
    for (int i = 0; i < SIZE; i++) begin
      if (ifm_wr_en[i] && wr_open) begin
        mem_q[wr_bank_q][i][ifm_wr_addr[AW*i +: AW]] <= pixels_in[W*i +: W];
      end
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_rd_lane
    assign out_data[W*g +: W] = mem_q[rd_bank_q][g][rd_ptr_q];
  end

  assign buf_ready = wr_open;
  assign out_valid = full_q[rd_bank_q];
  assign out_row   = rd_ptr_q;
  assign out_last  = out_valid && ({1'b0, rd_ptr_q} == (rows_q[rd_bank_q] - 6'd1));
  assign ovf_err   = ovf_q;

endmodule
